// File: rtl/pe_fwd_enable.sv
// Enable/data forwarding cell for one systolic PE: LANES x DW operands go right and down through DEPTH stages, plus local enable, burst mode latch and burst counter.
// Latency: DEPTH cycles from en_x/data_x to en_right/en_below outputs; en is combinational; burst_done/burst_len are registered one cycle after the ending beat.
// Backpressure: stall freezes every pipeline, FSM and counter register. Build option PE_FWD_DATA_ZERO_EN makes a stage with enable 0 load zero data.
module pe_fwd_enable #(
    parameter int DW     = 32,
    parameter int LANES  = 1,
    parameter int DEPTH  = 1,
    parameter int MODE_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  en_left,
    input  logic [LANES*DW-1:0]   data_left,
    input  logic                  en_above,
    input  logic [LANES*DW-1:0]   data_above,
    input  logic [MODE_W-1:0]     mode_left,
    output logic                  en_right,
    output logic [LANES*DW-1:0]   data_right,
    output logic                  en_below,
    output logic [LANES*DW-1:0]   data_below,
    output logic                  en,
    output logic [MODE_W-1:0]     mode_q,
    output logic                  burst_done,
    output logic [CNT_W-1:0]      burst_len,
    output logic                  err_misalign,
    input  logic                  err_clr
);

    localparam int W = LANES * DW;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic [DEPTH-1:0]  en_r_pipe, en_b_pipe;
    logic [W-1:0]      dat_r_pipe [DEPTH];
    logic [W-1:0]      dat_b_pipe [DEPTH];

    // Per-stage inputs: stage 0 takes the neighbour, stage k takes stage k-1
    logic [DEPTH-1:0]  en_r_src, en_b_src;
    logic [W-1:0]      dat_r_src [DEPTH];
    logic [W-1:0]      dat_b_src [DEPTH];
    logic [W-1:0]      dat_r_nxt [DEPTH];
    logic [W-1:0]      dat_b_nxt [DEPTH];

    assign en = en_left & en_above & ~stall;

    // Stage source selection and next-data policy for disabled beats
    always_comb begin
        en_r_src = '0;
        en_b_src = '0;
        for (int k = 0; k < DEPTH; k++) begin
            dat_r_src[k] = '0;
            dat_b_src[k] = '0;
        end
        en_r_src[0]  = en_left;
        en_b_src[0]  = en_above;
        dat_r_src[0] = data_left;
        dat_b_src[0] = data_above;
        for (int k = 1; k < DEPTH; k++) begin
            en_r_src[k]  = en_r_pipe[k-1];
            en_b_src[k]  = en_b_pipe[k-1];
            dat_r_src[k] = dat_r_pipe[k-1];
            dat_b_src[k] = dat_b_pipe[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
`ifdef PE_FWD_DATA_ZERO_EN
            // Disabled beat becomes a zero bubble
            dat_r_nxt[k] = en_r_src[k] ? dat_r_src[k] : '0;
            dat_b_nxt[k] = en_b_src[k] ? dat_b_src[k] : '0;
`else
            // Disabled beat keeps the stage's old data, only the enable moves
            dat_r_nxt[k] = en_r_src[k] ? dat_r_src[k] : dat_r_pipe[k];
            dat_b_nxt[k] = en_b_src[k] ? dat_b_src[k] : dat_b_pipe[k];
`endif
        end
    end

    // Right and below forwarding pipelines, frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r_pipe <= '0;
            en_b_pipe <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_r_pipe[k] <= '0;
                dat_b_pipe[k] <= '0;
            end
        end else if (!stall) begin
            en_r_pipe <= en_r_src;
            en_b_pipe <= en_b_src;
            for (int k = 0; k < DEPTH; k++) begin
                dat_r_pipe[k] <= dat_r_nxt[k];
                dat_b_pipe[k] <= dat_b_nxt[k];
            end
        end
    end

    assign en_right   = en_r_pipe[DEPTH-1];
    assign en_below   = en_b_pipe[DEPTH-1];
    assign data_right = dat_r_pipe[DEPTH-1];
    assign data_below = dat_b_pipe[DEPTH-1];

    // Burst FSM: latch mode on first beat, count beats, report length on exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mode_q     <= '0;
            burst_len  <= '0;
            burst_done <= 1'b0;
        end else if (stall) begin
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state  <= BURST;
                        mode_q <= mode_left;
                        cnt    <= CNT_W'(1);
                    end
                end
                BURST: begin
                    if (en) begin
                        if (cnt != '1)
                            cnt <= cnt + CNT_W'(1);
                    end else begin
                        state      <= IDLE;
                        burst_len  <= cnt;
                        burst_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky misalignment flag; a new misalign beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_misalign <= 1'b0;
        else if (!stall && (en_left != en_above))
            err_misalign <= 1'b1;
        else if (err_clr)
            err_misalign <= 1'b0;
    end

endmodule

// File: tb/tb_pe_fwd_enable.sv
// Directed bench for pe_fwd_enable with DW=8, LANES=2, DEPTH=2, CNT_W=3.
// Inputs change 1ns after each posedge; outputs are checked at that point.
// Summary line reports total checks and errors.
module tb_pe_fwd_enable;

    localparam int DW = 8, LANES = 2, DEPTH = 2, MODE_W = 3, CNT_W = 3;
    localparam int W = DW * LANES;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              en_left = 1'b0, en_above = 1'b0;
    logic [W-1:0]      data_left = '0, data_above = '0;
    logic [MODE_W-1:0] mode_left = '0;
    logic              err_clr = 1'b0;
    logic              en_right, en_below, en, burst_done, err_misalign;
    logic [W-1:0]      data_right, data_below;
    logic [MODE_W-1:0] mode_q;
    logic [CNT_W-1:0]  burst_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_fwd_enable #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH), .MODE_W(MODE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .en_left(en_left), .data_left(data_left),
        .en_above(en_above), .data_above(data_above),
        .mode_left(mode_left),
        .en_right(en_right), .data_right(data_right),
        .en_below(en_below), .data_below(data_below),
        .en(en), .mode_q(mode_q),
        .burst_done(burst_done), .burst_len(burst_len),
        .err_misalign(err_misalign), .err_clr(err_clr)
    );

    typedef struct {
        logic stall;
        logic en_l;
        logic en_a;
        logic exp_en;
    } en_vec_t;

    en_vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] dl(input int k);
        logic [7:0] hi, lo;
        hi = 8'(k * 34);
        lo = 8'(k * 17);
        return {hi, lo};
    endfunction

    function automatic logic [W-1:0] da(input int k);
        logic [7:0] hi, lo;
        hi = 8'(k * 7);
        lo = 8'(k * 5);
        return {hi, lo};
    endfunction

    task automatic beat(input int k, input logic [MODE_W-1:0] m);
        en_left    = 1'b1;
        en_above   = 1'b1;
        data_left  = dl(k);
        data_above = da(k);
        mode_left  = m;
        tick();
    endtask

    task automatic idle_in();
        en_left  = 1'b0;
        en_above = 1'b0;
        mode_left = '0;
    endtask

    initial begin
        logic [W-1:0] gap_exp_r, gap_exp_b;

        // Reset state
        #1;
        chk("rst_en_right", en_right, 0);
        chk("rst_data_right", data_right, 0);
        chk("rst_en_below", en_below, 0);
        chk("rst_data_below", data_below, 0);
        chk("rst_mode_q", mode_q, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_burst_len", burst_len, 0);
        chk("rst_err", err_misalign, 0);

        // Combinational enable truth table, applied while held in reset
        for (int i = 0; i < 8; i++) begin
            vecs[i].stall  = i[2];
            vecs[i].en_l   = i[1];
            vecs[i].en_a   = i[0];
            vecs[i].exp_en = (i == 3);
        end
        for (int i = 0; i < 8; i++) begin
            stall    = vecs[i].stall;
            en_left  = vecs[i].en_l;
            en_above = vecs[i].en_a;
            #1;
            chk($sformatf("en_table_%0d", i), en, vecs[i].exp_en);
        end
        stall = 1'b0;
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 5-beat burst, mode 3 on beat 1 then garbage mode on later beats
        for (int k = 1; k <= 5; k++) begin
            en_left = 1'b1; en_above = 1'b1;
            data_left = dl(k); data_above = da(k);
            mode_left = (k == 1) ? 3'd3 : 3'd5;
            #1;
            if (k == 1) chk("t1_en_first_beat", en, 1);
            tick();
            chk($sformatf("t1_mode_q_b%0d", k), mode_q, 3);
            chk($sformatf("t1_done_b%0d", k), burst_done, 0);
            if (k == 1) begin
                chk("t1_en_right_lat1", en_right, 0);
            end else begin
                chk($sformatf("t1_en_right_b%0d", k), en_right, 1);
                chk($sformatf("t1_data_right_b%0d", k), data_right, dl(k-1));
                chk($sformatf("t1_en_below_b%0d", k), en_below, 1);
                chk($sformatf("t1_data_below_b%0d", k), data_below, da(k-1));
            end
        end
        idle_in();
        tick();
        chk("t1_done_pulse", burst_done, 1);
        chk("t1_burst_len", burst_len, 5);
        chk("t1_data_right_last", data_right, dl(5));
        tick();
        chk("t1_done_one_cycle", burst_done, 0);
        chk("t1_en_right_gap", en_right, 0);
        chk("t1_en_below_gap", en_below, 0);
`ifdef PE_FWD_DATA_ZERO_EN
        gap_exp_r = '0;
        gap_exp_b = '0;
`else
        gap_exp_r = dl(5);
        gap_exp_b = da(5);
`endif
        chk("t5_data_right_gap", data_right, gap_exp_r);
        chk("t5_data_below_gap", data_below, gap_exp_b);
        chk("t1_mode_q_held", mode_q, 3);
        chk("t1_len_held", burst_len, 5);
        tick();

        // 4-beat burst with a 3-cycle stall after beat 2
        beat(1, 3'd6);
        beat(2, 3'd1);
        stall = 1'b1;
        #1;
        chk("t3_en_stalled", en, 0);
        for (int s = 0; s < 3; s++) begin
            if (s == 2) en_above = 1'b0;
            tick();
            chk($sformatf("t3_en_right_s%0d", s), en_right, 1);
            chk($sformatf("t3_data_right_s%0d", s), data_right, dl(1));
            chk($sformatf("t3_done_s%0d", s), burst_done, 0);
            chk($sformatf("t3_mode_s%0d", s), mode_q, 6);
            chk($sformatf("t3_err_s%0d", s), err_misalign, 0);
        end
        stall = 1'b0;
        beat(3, 3'd2);
        chk("t3_data_right_resume", data_right, dl(2));
        beat(4, 3'd2);
        idle_in();
        tick();
        chk("t3_done_pulse", burst_done, 1);
        chk("t3_burst_len", burst_len, 4);
        chk("t3_mode_q", mode_q, 6);
        tick();
        tick();

        // Misalignment: left on, above off for one cycle
        en_left = 1'b1; en_above = 1'b0;
        data_left = 16'hBEEF; data_above = 16'h1234;
        #1;
        chk("t4_en_misaligned", en, 0);
        tick();
        chk("t4_err_set", err_misalign, 1);
        idle_in();
        tick();
        chk("t4_en_right", en_right, 1);
        chk("t4_en_below", en_below, 0);
        chk("t4_data_right", data_right, 16'hBEEF);
        chk("t4_no_burst", burst_done, 0);
        tick();
        chk("t4_err_sticky", err_misalign, 1);
        err_clr = 1'b1;
        tick();
        chk("t4_err_cleared", err_misalign, 0);
        en_left = 1'b1;
        tick();
        chk("t4_set_wins", err_misalign, 1);
        en_left = 1'b0;
        tick();
        chk("t4_err_cleared2", err_misalign, 0);
        err_clr = 1'b0;
        tick();

        // 10-beat burst saturates a 3-bit counter
        for (int k = 1; k <= 10; k++) beat(k, 3'd4);
        idle_in();
        tick();
        chk("t5_done", burst_done, 1);
        chk("t5_len_saturated", burst_len, 7);
        tick();

        // Async reset in the middle of a burst
        beat(1, 3'd2);
        beat(2, 3'd2);
        beat(3, 3'd2);
        chk("t6_mode_before", mode_q, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_en_right", en_right, 0);
        chk("t6_data_right", data_right, 0);
        chk("t6_en_below", en_below, 0);
        chk("t6_data_below", data_below, 0);
        chk("t6_mode_q", mode_q, 0);
        chk("t6_burst_len", burst_len, 0);
        chk("t6_done", burst_done, 0);
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t6_no_done_%0d", c), burst_done, 0);
            chk($sformatf("t6_len_zero_%0d", c), burst_len, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
